// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, one bit per clock, LSB first
//
// Computes diff = a - b - b_in (mod 2^WIDTH) and b_out = (a < b + b_in)
// over WIDTH clock cycles.
//
// Ports:
//   clk    in   1      clock, rising edge active
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      begin a subtraction (accepted in IDLE or DONE)
//   a      in   WIDTH  minuend, captured when start is accepted
//   b      in   WIDTH  subtrahend, captured when start is accepted
//   b_in   in   1      borrow-in, captured when start is accepted
//   busy   out  1      high while bits are being processed (RUN)
//   done   out  1      one-cycle pulse, diff/b_out valid (DONE)
//   diff   out  WIDTH  result, held until the next completion
//   b_out  out  1      borrow-out, held until the next completion
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             br;
  logic [CW-1:0]    cnt;
  // Holds the WIDTH-1 result bits produced so far; the final bit is joined
  // on the completing cycle, so no storage bit is ever left unread.
  logic [WIDTH-2:0] sr;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_next;
  logic             accept;
  logic             last;

  assign ai      = opa[cnt];
  assign bi      = opb[cnt];
  assign d       = ai ^ bi ^ br;
  assign br_next = (~ai & bi) | (~(ai ^ bi) & br);
  assign accept  = start && (state != RUN);
  assign last    = (state == RUN) && (cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE accepts a new start directly for back-to-back use
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = (cnt == LAST) ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      sr    <= '0;
      diff  <= '0;
      b_out <= 1'b0;
    end else if (accept) begin
      opa <= a;
      opb <= b;
      br  <= b_in;
      cnt <= '0;
    end else if (state == RUN) begin
      // New bit enters at the MSB end; after WIDTH shifts bit 0 is the first.
      sr  <= (WIDTH-1)'({d, sr} >> 1);
      br  <= br_next;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff  <= {d, sr};
        b_out <= br_next;
      end
    end
  end

endmodule
